encoder_input_conditioner: RTL and testbench

ENCODER_INPUT_CONDITIONER -- requirements
Module: encoder_input_conditioner

---
 rtl/encoder_pkg.sv | 29 ++
 rtl/input_debouncer.sv | 47 ++++
 rtl/encoder_input_conditioner.sv | 152 +++++++++++++++
 tb/tb_encoder_input_conditioner.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the rotary encoder input conditioner.
package encoder_pkg;

  // Quadrature states; each encoding equals the {A,B} clean pair it tracks.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } quad_state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // Signed quarter-step accumulator; holds -4..+4 between detents.
  localparam int unsigned Q_W = 4;
  typedef logic signed [Q_W-1:0] quarter_t;

  // Next state in increment order 00->10->11->01->00.
  function automatic quad_state_t inc_next(input quad_state_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a saturating hold-time debounce counter.
// The clean output follows the synchronized level only after it has differed
// for DEBOUNCE_CYCLES consecutive cycles (DEBOUNCE_CYCLES must be >= 1).
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // Metastability guard: two flops, reset to the idle pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= RESET_LEVEL;
      sync_2 <= RESET_LEVEL;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Count disagreement cycles; flip clean on the last one, clear on agreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      clean <= RESET_LEVEL;
    end else if (sync_2 == clean) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      clean <= sync_2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/encoder_input_conditioner.sv
// Rotary encoder front end: debounces A, B and the push button, decodes
// quadrature into one step per detent, and produces button event pulses.
module encoder_input_conditioner
  import encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter logic [1:0]  IDLE_AB           = 2'b11
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_button,
  output logic a_clean,
  output logic b_clean,
  output logic button_clean,
  output logic step_valid,
  output logic step_dir,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic quad_error
);

  localparam quad_state_t IDLE_ST    = quad_state_t'(IDLE_AB);
  localparam quarter_t    Q_POS_FULL = quarter_t'(4);
  localparam quarter_t    Q_NEG_FULL = quarter_t'(-4);

  // A long press of 1 cycle would coincide with btn_press; the minimum
  // effective threshold is therefore 2 so the two pulses never share a cycle.
  localparam int unsigned LONG_EFF  = (LONG_PRESS_CYCLES < 2) ? 2 : LONG_PRESS_CYCLES;
  localparam int unsigned LP_W      = $clog2(LONG_EFF + 1);
  localparam logic [LP_W-1:0] LONG_LAST = LP_W'(LONG_EFF - 1);
  localparam logic [LP_W-1:0] LONG_HOLD = LP_W'(LONG_EFF);

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (IDLE_AB[1])
  ) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .clean(a_clean)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (IDLE_AB[0])
  ) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_b),
    .clean(b_clean)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) u_deb_btn (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_button),
    .clean(button_clean)
  );

  quad_state_t     st;
  quad_state_t     ab_st;
  quarter_t        q;
  quarter_t        q_next;
  logic            fwd;
  logic            bwd;
  logic            jump;
  logic            btn_prev;
  logic [LP_W-1:0] long_cnt;

  // Classify the current clean pair against the tracked state.
  always_comb begin
    ab_st  = quad_state_t'({a_clean, b_clean});
    fwd    = (ab_st == inc_next(st));
    bwd    = (st == inc_next(ab_st));
    jump   = (ab_st != st) && !fwd && !bwd;
    q_next = q;
    if (fwd) begin
      q_next = q + quarter_t'(1);
    end else if (bwd) begin
      q_next = q - quarter_t'(1);
    end
  end

  // Quadrature FSM: accumulate quarters, emit a step on a full detent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE_ST;
      q          <= '0;
      step_valid <= 1'b0;
      step_dir   <= DIR_DEC;
      quad_error <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      quad_error <= 1'b0;
      if (ab_st != st) begin
        st <= ab_st;
        if (jump) begin
          quad_error <= 1'b1;
          q          <= '0;
        end else if (ab_st == IDLE_ST) begin
          q <= '0;
          if (q_next == Q_POS_FULL) begin
            step_valid <= 1'b1;
            step_dir   <= DIR_INC;
          end else if (q_next == Q_NEG_FULL) begin
            step_valid <= 1'b1;
            step_dir   <= DIR_DEC;
          end
        end else begin
          q <= q_next;
        end
      end
    end
  end

  // Button edge pulses, one cycle after the clean level changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev    <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_prev    <= button_clean;
      btn_press   <= button_clean & ~btn_prev;
      btn_release <= ~button_clean & btn_prev;
    end
  end

  // Long-press timer: counts past the threshold once and parks there,
  // so the pulse fires a single time per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_cnt <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= button_clean && (long_cnt == LONG_LAST);
      if (!button_clean) begin
        long_cnt <= '0;
      end else if (long_cnt != LONG_HOLD) begin
        long_cnt <= long_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Directed self-checking bench for encoder_input_conditioner
// (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, IDLE_AB=2'b11).
// Raw-to-clean latency is 2+4=6 cycles; FSM/button pulses follow 1 cycle later.
module tb_encoder_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic raw_a, raw_b, raw_button;
  logic a_clean, b_clean, button_clean;
  logic step_valid, step_dir;
  logic btn_press, btn_release, btn_long;
  logic quad_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor state (updated 1 time unit after each rising edge)
  int   cyc = 0;
  int   n_step = 0, n_err = 0, n_press = 0, n_rel = 0, n_long = 0;
  int   n_both = 0, n_achg = 0;
  int   step_cyc = -1, err_cyc = -1, press_cyc = -1, rel_cyc = -1, long_cyc = -1;
  int   b_rise_cyc = -1;
  logic last_dir = 1'bx;
  logic a_prev = 1'b1, b_prev = 1'b1;

  encoder_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .IDLE_AB          (2'b11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .raw_button  (raw_button),
    .a_clean     (a_clean),
    .b_clean     (b_clean),
    .button_clean(button_clean),
    .step_valid  (step_valid),
    .step_dir    (step_dir),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .quad_error  (quad_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (step_valid) begin n_step++; last_dir = step_dir; step_cyc = cyc; end
    if (quad_error) begin n_err++; err_cyc = cyc; end
    if (step_valid && quad_error) n_both++;
    if (btn_press) begin n_press++; press_cyc = cyc; end
    if (btn_release) begin n_rel++; rel_cyc = cyc; end
    if (btn_long) begin n_long++; long_cyc = cyc; end
    if (a_clean !== a_prev) n_achg++;
    if (b_clean === 1'b1 && b_prev === 1'b0) b_rise_cyc = cyc;
    a_prev = a_clean;
    b_prev = b_clean;
  end

  // Drive raw A/B at a falling edge and hold for 8 cycles; d = edge index.
  task automatic drive_ab(input logic a, input logic b, output int d);
    raw_a = a;
    raw_b = b;
    d = cyc;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; raw_a = 1'b1; raw_b = 1'b1; raw_button = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_clean, b_clean, button_clean} !== 3'b110) begin
      n_fail++; $display("FAIL reset_clean: got %b expected 110", {a_clean, b_clean, button_clean});
    end
    n_checks++;
    if ({step_valid, quad_error, btn_press, btn_release, btn_long} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000",
                         {step_valid, quad_error, btn_press, btn_release, btn_long});
    end
    n_checks++;
    if (dut.q !== 4'b0000) begin
      n_fail++; $display("FAIL reset_q: got %b expected 0000", dut.q);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({step_valid, quad_error, btn_press, btn_release, btn_long} !== 5'b0) begin
      n_fail++; $display("FAIL post_reset_pulses: got %b expected 00000",
                         {step_valid, quad_error, btn_press, btn_release, btn_long});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_step + n_err + n_press + n_rel + n_long != 0) begin
      n_fail++; $display("FAIL idle_events: got %0d expected 0", n_step + n_err + n_press + n_rel + n_long);
    end
  endtask

  task automatic test_increment;
    int s0, e0, d;
    s0 = n_step; e0 = n_err;
    drive_ab(1'b0, 1'b1, d);
    drive_ab(1'b0, 1'b0, d);
    drive_ab(1'b1, 1'b0, d);
    drive_ab(1'b1, 1'b1, d);
    n_checks++;
    if (n_step - s0 != 1) begin
      n_fail++; $display("FAIL inc_step_count: got %0d expected 1", n_step - s0);
    end
    n_checks++;
    if (last_dir !== 1'b1) begin
      n_fail++; $display("FAIL inc_dir: got %b expected 1", last_dir);
    end
    n_checks++;
    if (b_rise_cyc != d + 6) begin
      n_fail++; $display("FAIL inc_b_rise_cycle: got %0d expected %0d", b_rise_cyc, d + 6);
    end
    n_checks++;
    if (step_cyc != d + 7) begin
      n_fail++; $display("FAIL inc_step_cycle: got %0d expected %0d", step_cyc, d + 7);
    end
    n_checks++;
    if (n_err != e0) begin
      n_fail++; $display("FAIL inc_no_error: got %0d expected %0d", n_err, e0);
    end
  endtask

  task automatic test_bounce;
    int a0, s0, e0, last, d;
    a0 = n_achg; s0 = n_step; e0 = n_err; last = 0;
    for (int i = 0; i < 11; i++) begin
      raw_a = ~raw_a;
      last = cyc;
      if (i < 10) repeat (2) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (a_clean !== 1'b1 || n_achg != a0) begin
      n_fail++; $display("FAIL bounce_early: got a_clean=%b changes=%0d expected a_clean=1 changes=0",
                         a_clean, n_achg - a0);
    end
    @(negedge clk);
    n_checks++;
    if (a_clean !== 1'b0 || n_achg - a0 != 1) begin
      n_fail++; $display("FAIL bounce_settle: got a_clean=%b changes=%0d expected a_clean=0 changes=1 at +%0d",
                         a_clean, n_achg - a0, cyc - last);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_err != e0 || n_step != s0) begin
      n_fail++; $display("FAIL bounce_events: got err=%0d step=%0d expected 0 0", n_err - e0, n_step - s0);
    end
    drive_ab(1'b1, 1'b1, d);
    n_checks++;
    if (n_step != s0 || n_err != e0 || a_clean !== 1'b1) begin
      n_fail++; $display("FAIL bounce_return: got step=%0d err=%0d a_clean=%b expected 0 0 1",
                         n_step - s0, n_err - e0, a_clean);
    end
  endtask

  task automatic test_backtrack;
    int s0, e0, d;
    s0 = n_step; e0 = n_err;
    drive_ab(1'b1, 1'b0, d);
    n_checks++;
    if (dut.q !== 4'b1111) begin
      n_fail++; $display("FAIL backtrack_q_partial: got %b expected 1111", dut.q);
    end
    drive_ab(1'b1, 1'b1, d);
    n_checks++;
    if (dut.q !== 4'b0000 || n_step != s0 || n_err != e0) begin
      n_fail++; $display("FAIL backtrack_none: got q=%b step=%0d err=%0d expected 0000 0 0",
                         dut.q, n_step - s0, n_err - e0);
    end
    drive_ab(1'b1, 1'b0, d);
    drive_ab(1'b0, 1'b0, d);
    drive_ab(1'b0, 1'b1, d);
    drive_ab(1'b1, 1'b1, d);
    n_checks++;
    if (n_step - s0 != 1 || last_dir !== 1'b0) begin
      n_fail++; $display("FAIL dec_step: got count=%0d dir=%b expected 1 0", n_step - s0, last_dir);
    end
    n_checks++;
    if (step_cyc != d + 7) begin
      n_fail++; $display("FAIL dec_step_cycle: got %0d expected %0d", step_cyc, d + 7);
    end
  endtask

  task automatic test_illegal;
    int s0, e0, d;
    s0 = n_step; e0 = n_err;
    drive_ab(1'b0, 1'b0, d);
    n_checks++;
    if (n_err - e0 != 1 || err_cyc != d + 7) begin
      n_fail++; $display("FAIL jump_error: got count=%0d cycle=%0d expected 1 %0d", n_err - e0, err_cyc, d + 7);
    end
    drive_ab(1'b1, 1'b1, d);
    n_checks++;
    if (n_err - e0 != 2 || n_step != s0) begin
      n_fail++; $display("FAIL jump_back: got err=%0d step=%0d expected 2 0", n_err - e0, n_step - s0);
    end
  endtask

  task automatic test_button;
    int p0, r0, l0, d, r;
    p0 = n_press; r0 = n_rel; l0 = n_long;
    raw_button = 1'b1;
    d = cyc;
    repeat (26) @(negedge clk);
    n_checks++;
    if (n_press - p0 != 1 || press_cyc != d + 7) begin
      n_fail++; $display("FAIL btn_press: got count=%0d cycle=%0d expected 1 %0d", n_press - p0, press_cyc, d + 7);
    end
    n_checks++;
    if (n_long - l0 != 1 || long_cyc != d + 16) begin
      n_fail++; $display("FAIL btn_long: got count=%0d cycle=%0d expected 1 %0d", n_long - l0, long_cyc, d + 16);
    end
    n_checks++;
    if (n_rel != r0 || button_clean !== 1'b1) begin
      n_fail++; $display("FAIL btn_held: got rel=%0d clean=%b expected 0 1", n_rel - r0, button_clean);
    end
    raw_button = 1'b0;
    r = cyc;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_rel - r0 != 1 || rel_cyc != r + 7) begin
      n_fail++; $display("FAIL btn_release: got count=%0d cycle=%0d expected 1 %0d", n_rel - r0, rel_cyc, r + 7);
    end
    n_checks++;
    if (n_long - l0 != 1 || n_press - p0 != 1 || button_clean !== 1'b0) begin
      n_fail++; $display("FAIL btn_after_release: got long=%0d press=%0d clean=%b expected 1 1 0",
                         n_long - l0, n_press - p0, button_clean);
    end
  endtask

  task automatic test_reset_mid;
    int s0, e0, p0, r0, l0, d, rd;
    s0 = n_step; e0 = n_err; p0 = n_press; r0 = n_rel; l0 = n_long;
    drive_ab(1'b0, 1'b1, d);
    raw_a = 1'b0; raw_b = 1'b0; raw_button = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (dut.q !== 4'b0010 || n_press - p0 != 1) begin
      n_fail++; $display("FAIL mid_pre_reset: got q=%b press=%0d expected 0010 1", dut.q, n_press - p0);
    end
    rst = 1'b1;
    raw_button = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_clean, b_clean, button_clean} !== 3'b110 || dut.q !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_state: got clean=%b q=%b expected 110 0000",
                         {a_clean, b_clean, button_clean}, dut.q);
    end
    @(negedge clk);
    rst = 1'b0;
    rd = cyc;
    @(negedge clk);
    n_checks++;
    if ({step_valid, quad_error, btn_press, btn_release, btn_long} !== 5'b0) begin
      n_fail++; $display("FAIL mid_first_cycle: got %b expected 00000",
                         {step_valid, quad_error, btn_press, btn_release, btn_long});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_err - e0 != 1 || err_cyc != rd + 7) begin
      n_fail++; $display("FAIL mid_resync_jump: got count=%0d cycle=%0d expected 1 %0d", n_err - e0, err_cyc, rd + 7);
    end
    drive_ab(1'b1, 1'b0, d);
    drive_ab(1'b1, 1'b1, d);
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_step != s0 || n_long != l0 || n_rel != r0 || n_press - p0 != 1) begin
      n_fail++; $display("FAIL mid_no_events: got step=%0d long=%0d rel=%0d press=%0d expected 0 0 0 1",
                         n_step - s0, n_long - l0, n_rel - r0, n_press - p0);
    end
  endtask

  task automatic test_exclusive;
    n_checks++;
    if (n_both != 0) begin
      n_fail++; $display("FAIL step_error_overlap: got %0d expected 0", n_both);
    end
  endtask

  initial begin
    test_reset;
    test_increment;
    test_bounce;
    test_backtrack;
    test_illegal;
    test_button;
    test_reset_mid;
    test_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
